// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run / slow-run / single-step / halt controller producing the datapath enable.
// Define CYCLE_CNT_EN to build the live enabled-cycle counter; otherwise cycle_cnt reads 0.

module cpu_run_ctrl #(
   parameter int SLOW_DIV = 25_000_000,
   parameter int DEBOUNCE = 500_000,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frequency,
   input  logic             run,
   input  logic             step_btn,
   input  logic             halt_req,
   input  logic             resume,
   output logic             cpu_en,
   output logic             halted,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_HALT  = 2'b11;

   localparam int DIV_W = $clog2(SLOW_DIV);
   localparam int DB_W  = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

   logic [2:0]       meta_reg;
   logic [2:0]       sync_reg;
   logic             freq_s;
   logic             run_s;
   logic             btn_s;
   logic             freq_change;

   logic [DB_W-1:0]  db_cnt_reg;
   logic             db_level_reg;
   logic             db_prev_reg;
   logic             step_fire_reg;

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_next;

   // Two-flop synchronizers for {frequency, run, step_btn}
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= {frequency, run, step_btn};
         sync_reg <= meta_reg;
      end
   end

   assign freq_s      = sync_reg[2];
   assign run_s       = sync_reg[1];
   assign btn_s       = sync_reg[0];
   // freq_s is about to change on this edge when the first stage disagrees with it
   assign freq_change = meta_reg[2] ^ sync_reg[2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt_reg    <= '0;
         db_level_reg  <= 1'b0;
         db_prev_reg   <= 1'b0;
         step_fire_reg <= 1'b0;
      end else begin
         db_prev_reg   <= db_level_reg;
         step_fire_reg <= db_level_reg & ~db_prev_reg;
         if (btn_s == db_level_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_LAST) begin
            db_level_reg <= btn_s;
            db_cnt_reg   <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
         end
      end
   end

   // A step pulse only counts in PAUSE and only if we are not leaving for RUN on the same edge
   always_comb begin
      cpu_en = 1'b0;
      case (state_reg)
         ST_RUN:   cpu_en = freq_s | (div_reg == DIV_LAST);
         ST_PAUSE: cpu_en = step_fire_reg & ~run_s;
         default:  cpu_en = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      if (cpu_en && halt_req) begin
         state_next = ST_HALT;
      end else begin
         case (state_reg)
            ST_IDLE, ST_RUN, ST_PAUSE: state_next = run_s ? ST_RUN : ST_PAUSE;
            ST_HALT: begin
               if (resume) state_next = run_s ? ST_RUN : ST_PAUSE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      div_next = '0;
      if (state_reg == ST_RUN && state_next == ST_RUN && !freq_change) begin
         div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         div_reg   <= '0;
      end else begin
         state_reg <= state_next;
         div_reg   <= div_next;
      end
   end

   assign state  = state_reg;
   assign halted = (state_reg == ST_HALT);

`ifdef CYCLE_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt_reg <= '0;
      end else if (cpu_en) begin
         cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      end
   end

   assign cycle_cnt = cycle_cnt_reg;
`else
   assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random switch/button/halt traffic,
// every cycle compared against a behavioural model of the run/step/halt rules.

module tb_cpu_run_ctrl;

   localparam int SLOW_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int CNT_W    = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             frequency;
   logic             run;
   logic             step_btn;
   logic             halt_req;
   logic             resume;
   logic             cpu_en;
   logic             halted;
   logic [1:0]       state;
   logic [CNT_W-1:0] cycle_cnt;

   int n_checks = 0;
   int n_errors = 0;

   cpu_run_ctrl #(
      .SLOW_DIV (SLOW_DIV),
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .frequency (frequency),
      .run       (run),
      .step_btn  (step_btn),
      .halt_req  (halt_req),
      .resume    (resume),
      .cpu_en    (cpu_en),
      .halted    (halted),
      .state     (state),
      .cycle_cnt (cycle_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode 0 idle, 1 run, 2 pause, 3 halt
   int m_mode;
   bit m_f1, m_f2, m_r1, m_r2, m_b1, m_b2;
   bit m_db;
   int m_db_len;
   bit m_rose;
   bit m_fire;
   int m_phase;
   int m_count;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cnt_exp(input int v);
`ifdef CYCLE_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   function automatic bit model_en();
      if (m_mode == 1) return m_f2 || (m_phase == SLOW_DIV - 1);
      if (m_mode == 2) return m_fire && !m_r2;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_f1 = 0; m_f2 = 0; m_r1 = 0; m_r2 = 0; m_b1 = 0; m_b2 = 0;
      m_db = 0; m_db_len = 0; m_rose = 0; m_fire = 0;
      m_phase = 0; m_count = 0;
   endtask

   task automatic model_step();
      bit en;
      int nxt;
      en = model_en();
      if (en && halt_req) nxt = 3;
      else if (m_mode == 3 && !resume) nxt = 3;
      else nxt = m_r2 ? 1 : 2;
      if (nxt == 1 && m_mode == 1 && m_f1 == m_f2) m_phase = (m_phase + 1) % SLOW_DIV;
      else m_phase = 0;
      m_count = (m_count + int'(en)) % (1 << CNT_W);
      m_fire = m_rose;
      m_rose = 0;
      if (m_b2 != m_db) begin
         m_db_len++;
         if (m_db_len == DEBOUNCE) begin
            m_db = m_b2;
            m_db_len = 0;
            m_rose = m_db;
         end
      end else begin
         m_db_len = 0;
      end
      m_mode = nxt;
      m_f2 = m_f1; m_r2 = m_r1; m_b2 = m_b1;
      m_f1 = frequency; m_r1 = run; m_b1 = step_btn;
   endtask

   task automatic compare_all(input string tag);
      check_val({tag, ".cpu_en"},    32'(cpu_en),    32'(model_en()));
      check_val({tag, ".halted"},    32'(halted),    32'(m_mode == 3));
      check_val({tag, ".state"},     32'(state),     32'(m_mode));
      check_val({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(cnt_exp(m_count)));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) model_step();
      @(negedge clk);
      compare_all(tag);
   endtask

   // Asserts reset away from any clock edge; leaves rst low, caller releases it
   task automatic do_reset(input int cycles, input string tag);
      rst = 1'b0;
      model_reset();
      #1;
      compare_all({tag, ".async"});
      for (int i = 0; i < cycles; i++) tick(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int pulses;
      int gap;
      int last;

      rst = 1'b1; frequency = 1'b1; run = 1'b1; step_btn = 1'b0;
      halt_req = 1'b0; resume = 1'b0;
      model_reset();
      #2;

      // Reset then fast run
      do_reset(5, "reset");
      rst = 1'b1;
      n = 0;
      while (cpu_en !== 1'b1 && n < 10) begin
         tick("boot");
         n++;
      end
      check_val("first_en_edge", n, 3);
      for (int i = 0; i < 10; i++) tick("fast");
      check_val("fast_cnt10", 32'(cycle_cnt), cnt_exp(10));
      $display("[tb] reset/fast run: %0d checks", n_checks);

      // Slow run
      frequency = 1'b0;
      for (int i = 0; i < 8; i++) tick("slow_settle");
      pulses = 0; last = -1; gap = 0;
      for (int i = 0; i < 20; i++) begin
         tick("slow");
         if (cpu_en === 1'b1) begin
            if (last >= 0) gap = i - last;
            last = i;
            pulses++;
         end
      end
      check_val("slow_pulses", pulses, 5);
      check_val("slow_gap", gap, 4);
      $display("[tb] slow run: %0d checks", n_checks);

      // Step with bounce
      run = 1'b0; frequency = 1'b1;
      for (int i = 0; i < 6; i++) tick("to_pause");
      check_val("pause_state", 32'(state), 2);
      step_btn = 1'b1; tick("bounce");
      step_btn = 1'b0; tick("bounce");
      step_btn = 1'b1;
      n = 0;
      while (cpu_en !== 1'b1 && n < 20) begin
         tick("step1");
         n++;
      end
      check_val("step_latency", n, 6);
      pulses = (cpu_en === 1'b1) ? 1 : 0;
      for (int i = 0; i < 12; i++) begin
         tick("step1_hold");
         if (cpu_en === 1'b1) pulses++;
      end
      check_val("step1_pulses", pulses, 1);
      step_btn = 1'b0;
      for (int i = 0; i < 10; i++) tick("step_release");
      step_btn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick("step2");
         if (cpu_en === 1'b1) pulses++;
      end
      check_val("step2_pulses", pulses, 1);
      step_btn = 1'b0;
      for (int i = 0; i < 8; i++) tick("step_release");
      $display("[tb] single step: %0d checks", n_checks);

      // Halt on 5th enable
      do_reset(2, "halt_rst");
      rst = 1'b1; run = 1'b1; frequency = 1'b1;
      n = 0; pulses = 0;
      while (pulses < 5 && n < 50) begin
         tick("pre_halt");
         n++;
         if (cpu_en === 1'b1) pulses++;
      end
      check_val("halt_wait", pulses, 5);
      halt_req = 1'b1;
      tick("halt_edge");
      halt_req = 1'b0;
      check_val("halt_state", 32'(state), 3);
      check_val("halt_flag", 32'(halted), 1);
      check_val("halt_en", 32'(cpu_en), 0);
      check_val("halt_cnt", 32'(cycle_cnt), cnt_exp(5));
      step_btn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick("halt_btn");
         if (cpu_en === 1'b1) pulses++;
      end
      step_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick("halt_btn");
         if (cpu_en === 1'b1) pulses++;
      end
      check_val("halt_btn_pulses", pulses, 0);
      check_val("halt_cnt_hold", 32'(cycle_cnt), cnt_exp(5));

      // Resume into RUN
      resume = 1'b1;
      tick("resume");
      resume = 1'b0;
      check_val("resume_state", 32'(state), 1);
      tick("resume_run");
      check_val("resume_en", 32'(cpu_en), 1);

      // Halt request coinciding with a run fall
      run = 1'b0;
      tick("run_fall");
      tick("run_fall");
      check_val("pre_collide_en", 32'(cpu_en), 1);
      halt_req = 1'b1;
      tick("halt_vs_pause");
      halt_req = 1'b0;
      check_val("collide_state", 32'(state), 3);
      resume = 1'b1;
      tick("resume_pause");
      resume = 1'b0;
      check_val("resume_pause_state", 32'(state), 2);
      $display("[tb] halt/resume: %0d checks", n_checks);

      // Counter wrap
      do_reset(2, "wrap_rst");
      rst = 1'b1; run = 1'b1; frequency = 1'b1;
      n = 0;
      while (cpu_en !== 1'b1 && n < 10) begin
         tick("wrap_boot");
         n++;
      end
      for (int i = 0; i < 255; i++) tick("wrap");
      check_val("wrap_255", 32'(cycle_cnt), cnt_exp(255));
      tick("wrap");
      check_val("wrap_0", 32'(cycle_cnt), 0);
      $display("[tb] counter wrap: %0d checks", n_checks);

      // Random traffic
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 39) == 0) run = ~run;
         if ($urandom_range(0, 39) == 0) frequency = ~frequency;
         if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
         halt_req = ($urandom_range(0, 15) == 0);
         resume   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1, "rand_rst");
            rst = 1'b1;
         end
         tick("random");
      end
      halt_req = 1'b0; resume = 1'b0;
      $display("[tb] random traffic: %0d checks", n_checks);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

- Run/step controller for the 5-stage MIPS datapath.
- Generates the single-cycle pipeline enable `cpu_en`. Every datapath register and memory write qualifies on it.
- Supports free-running at board clock, free-running at a divided slow rate, single-stepping from a debounced push button, and halting on a datapath halt request (syscall).
- Sits between the board I/O (switches, button) and `data_route`. Its state and enabled-cycle count are exported for the seven-segment display.

## Interface

Parameters:
- `SLOW_DIV`, 25_000_000: board cycles per enable in slow run; legal ≥ 2.
- `DEBOUNCE`, 500_000: consecutive stable cycles needed to accept a button level change; legal ≥ 1.
- `CNT_W`, 32: width of the enabled-cycle counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `frequency`  in  1  async switch; 1 = fast run (every cycle), 0 = slow run (every `SLOW_DIV` cycles).
- `run`  in  1  async switch; 1 = run, 0 = pause/step mode.
- `step_btn`  in  1  raw async push button, active-high.
- `halt_req`  in  1  synchronous from datapath; meaningful only in cycles where `cpu_en`=1.
- `resume`  in  1  synchronous one-cycle pulse; leaves HALT.
- `cpu_en`  out  1  datapath enable.
- `halted`  out  1  1 while in HALT.
- `state`  out  2  current state encoding.
- `cycle_cnt`  out  `CNT_W`  count of `cpu_en` cycles.

## Operation

Input conditioning:
- `frequency`, `run` and `step_btn` each pass through a 2-flop synchronizer; the outputs are `freq_s`, `run_s`, `btn_s`.
- Debouncer: `db_level` flips only after `btn_s` has differed from it for `DEBOUNCE` consecutive cycles. Any return to equality clears the count.
- `step_fire` is a registered one-cycle pulse on each 0→1 edge of `db_level`.

State machine:
- IDLE = 00. Entered on reset; lasts exactly one cycle. Next state is RUN if `run_s`, else PAUSE.
- RUN = 01.
  - `freq_s`=1: `cpu_en`=1 every cycle.
  - `freq_s`=0: `cpu_en`=1 only when `div == SLOW_DIV-1`.
  - `run_s`=0 → PAUSE.
- PAUSE = 10.
  - `cpu_en` = `step_fire`, i.e. exactly one enabled cycle per button press.
  - `run_s`=1 → RUN.
- HALT = 11.
  - `cpu_en`=0.
  - `resume`=1 → RUN if `run_s`, else PAUSE.
  - `run`, `step_btn` and `frequency` changes are ignored.

Halt handling and priorities:
- At any edge where `cpu_en`=1 and `halt_req`=1, the next state is HALT.
- This takes priority over every other transition, including a simultaneous `run_s` change.

Divider:
- `div` counts 0..`SLOW_DIV-1` in RUN and wraps to 0.
- `div` is cleared on entry to RUN and on any `freq_s` change.
- In all other states `div` is held at 0.

Step pulses outside PAUSE:
- `step_fire` in RUN, HALT or IDLE is discarded.
- `step_fire` on the same edge as a PAUSE→RUN transition is discarded.

Cycle counter:
- `cycle_cnt` increments by 1 at every edge where `cpu_en`=1.
- It wraps modulo 2^`CNT_W`.

Outputs:
- `cpu_en` is decoded combinationally from registered state only (`state`, `div`, `freq_s`, `step_fire`). It has no path from the raw inputs.
- `halted` = (`state` == HALT).

## Timing

- Reset (`rst`=0), asynchronous:
  - `state`=IDLE, `cpu_en`=0, `halted`=0, `cycle_cnt`=0, `div`=0.
  - `db_level`=0, `step_fire`=0, synchronizers=0.
- Reset asserted mid-operation kills any pending step and debounce count immediately. No `cpu_en` occurs while `rst`=0.
- First `cpu_en` after reset release, with `run`=1 and `frequency`=1 held stable:
  - 2 edges to synchronize, 1 edge in IDLE.
  - `cpu_en` first high in the cycle after the 3rd edge.
- Slow run: first `cpu_en` occurs `SLOW_DIV` cycles after RUN entry, then every `SLOW_DIV` cycles. It is high for exactly 1 cycle.
- Step latency: `step_fire` (and therefore `cpu_en`) is high in the cycle following edge `DEBOUNCE`+3. Edge 1 is the first edge that samples `step_btn`=1.
- Halt: the state is HALT from the edge that sampled `halt_req`. `cpu_en` is 0 from the following cycle.
- Resume: the new state is valid from the edge that samples `resume`.
- Switch changes take effect 2 edges after the change (synchronizer delay), then one further edge for the state transition.

## Configuration

- `CYCLE_CNT_EN` defined: `cycle_cnt` is a live `CNT_W`-bit counter, as described above.
- `CYCLE_CNT_EN` undefined:
  - No counter register is built; `cycle_cnt` is tied to 0.
  - All other behaviour is unchanged.

## Test plan

Bench parameters: `SLOW_DIV`=4, `DEBOUNCE`=3, `CNT_W`=8, `CYCLE_CNT_EN` defined.

- Reset then fast run: hold `rst`=0 for 5 cycles with `run`=1, `frequency`=1, then release → all outputs 0 during reset; `cpu_en`=1 continuously from the cycle after the 3rd edge; `cycle_cnt`=10 after 10 enables.
- Slow run: `frequency`=0 → `cpu_en` is a 1-cycle pulse every 4 cycles; `cycle_cnt` advances by 1 per 4 cycles.
- Step with bounce: `run`=0, then `step_btn` toggles 1,0,1 on successive cycles and then holds 1 → exactly one `cpu_en` pulse, at edge 6 after the stable rise; `cycle_cnt`+1. A second clean press gives a second pulse.
- Halt: fast run, assert `halt_req`=1 on the 5th `cpu_en` → `halted`=1, `state`=11, `cpu_en`=0 thereafter; button presses have no effect; `cycle_cnt`=5.
- Resume: pulse `resume` with `run`=1 → `state`=01 next cycle and `cpu_en` resumes. Also `halt_req` on the same edge as a `run` falling edge → HALT wins.
- Wrap: run 256 fast enables → `cycle_cnt` returns to 0. Rebuild without `CYCLE_CNT_EN` → `cycle_cnt` stays 0 throughout.
